// File: rtl/sync_fifo_pkg.sv
// Shared sizing and pointer helpers for the single-clock FIFO.
// Used by sync_fifo_ctrl and sync_fifo_mem (SYNC_FIFO_FWFT_EN selects the read mode).
package sync_fifo_pkg;

    localparam int unsigned DEF_DATA_W   = 8;
    localparam int unsigned DEF_DEPTH    = 90;
    localparam int unsigned DEF_AF_LEVEL = 80;
    localparam int unsigned DEF_AE_LEVEL = 8;

    // Occupancy must be able to represent DEPTH itself, hence DEPTH+1 states.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Explicit wrap so non-power-of-2 depths index only valid entries.
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

    function automatic bit levels_ok(input int unsigned ae_level, input int unsigned af_level);
        return ae_level < af_level;
    endfunction

    localparam bit DEF_LEVELS_OK = levels_ok(DEF_AE_LEVEL, DEF_AF_LEVEL);

endpackage

// File: rtl/sync_fifo_mem.sv
// DATA_W x DEPTH storage with synchronous write; registered read port by default,
// asynchronous read port when SYNC_FIFO_FWFT_EN is defined.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    localparam int unsigned ADDR_W = ptr_w(DEPTH)
) (
    input  logic              clk,
`ifndef SYNC_FIFO_FWFT_EN
    input  logic              rst,
    input  logic              rd_en,
`endif
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rd_data = mem_q[rd_addr];
`else
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;

    // Output word holds between accepted reads.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
`endif

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO control: pointers, occupancy, level and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned AF_LEVEL = DEF_AF_LEVEL,
    parameter int unsigned AE_LEVEL = DEF_AE_LEVEL,
    localparam int unsigned CNT_W   = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] d_in,
    input  logic              wren,
    input  logic              rden,
    input  logic              flag_clr,
    output logic [DATA_W-1:0] d_out,
    output logic              rd_valid,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned PTR_W = ptr_w(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             af_q, af_d;
    logic             ae_q, ae_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             wr_acc;
    logic             rd_acc;
    logic [DATA_W-1:0] mem_rd_data;

    // Everything is decided on pre-edge flags; flags are re-derived from the new count.
    always_comb begin
        wr_acc   = wren & ~full_q;
        rd_acc   = rden & ~empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_acc) begin
            wr_ptr_d = PTR_W'(next_ptr(32'(wr_ptr_q), DEPTH));
        end
        if (rd_acc) begin
            rd_ptr_d = PTR_W'(next_ptr(32'(rd_ptr_q), DEPTH));
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
        af_d    = (count_d >= CNT_W'(AF_LEVEL));
        ae_d    = (count_d <= CNT_W'(AE_LEVEL));

        // Set dominates a same-cycle clear.
        ovf_d = (wren & full_q)  | (ovf_q & ~flag_clr);
        udf_d = (rden & empty_q) | (udf_q & ~flag_clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    sync_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
`ifndef SYNC_FIFO_FWFT_EN
        .rst     (rst),
        .rd_en   (rd_acc),
`endif
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q),
        .wr_data (d_in),
        .rd_addr (rd_ptr_q),
        .rd_data (mem_rd_data)
    );

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is presented as soon as the FIFO is non-empty.
    assign rd_valid = ~empty_q;
`else
    logic rd_valid_q, rd_valid_d;

    always_comb begin
        rd_valid_d = rd_acc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_valid = rd_valid_q;
`endif

    assign d_out        = mem_rd_data;
    assign fifo_full    = full_q;
    assign fifo_empty   = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl at DEPTH=6, AF_LEVEL=5, AE_LEVEL=1.
// Expectations follow SYNC_FIFO_FWFT_EN when the bench is built with it.
module tb_sync_fifo_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] d_in;
    logic       wren;
    logic       rden;
    logic       flag_clr;
    logic [7:0] d_out;
    logic       rd_valid;
    logic       fifo_full;
    logic       fifo_empty;
    logic       almost_full;
    logic       almost_empty;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;

    int total;
    int bad;

    logic [7:0] stream_exp [11];

    sync_fifo_ctrl #(
        .DATA_W   (8),
        .DEPTH    (6),
        .AF_LEVEL (5),
        .AE_LEVEL (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .d_in         (d_in),
        .wren         (wren),
        .rden         (rden),
        .flag_clr     (flag_clr),
        .d_out        (d_out),
        .rd_valid     (rd_valid),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; wren = 1'b0; rden = 1'b0; flag_clr = 1'b0; d_in = 8'h00;
        #2 rst = 1'b0;
        #1;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0h exp=0", count); end
        total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", fifo_empty); end
        total++; if (almost_empty !== 1'b1) begin bad++; $display("FAIL reset_ae got=%b exp=1", almost_empty); end
        total++; if (fifo_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", fifo_full); end
        total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL reset_af got=%b exp=0", almost_full); end
        total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL reset_err got=%b%b exp=00", overflow, underflow); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
`ifndef SYNC_FIFO_FWFT_EN
        total++; if (d_out !== 8'h00) begin bad++; $display("FAIL reset_d_out got=%0h exp=0", d_out); end
`endif
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            wren = 1'b1;
            d_in = 8'h11 + 8'(i);
            @(posedge clk); #1;
            total++; if (count !== 3'(i + 1)) begin bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i + 1); end
            total++; if (almost_empty !== ((i + 1) <= 1)) begin bad++; $display("FAIL fill_ae[%0d] got=%b exp=%b", i, almost_empty, (i + 1) <= 1); end
            total++; if (almost_full !== ((i + 1) >= 5)) begin bad++; $display("FAIL fill_af[%0d] got=%b exp=%b", i, almost_full, (i + 1) >= 5); end
            total++; if (fifo_full !== (i == 5)) begin bad++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, fifo_full, i == 5); end
            total++; if (fifo_empty !== 1'b0) begin bad++; $display("FAIL fill_empty[%0d] got=%b exp=0", i, fifo_empty); end
        end
        @(negedge clk);
        wren = 1'b0;
    endtask

    task automatic test_overflow();
        @(negedge clk);
        wren = 1'b1; d_in = 8'h77;
        @(posedge clk); #1;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        total++; if (count !== 3'd6) begin bad++; $display("FAIL ovf_count got=%0d exp=6", count); end
        total++; if (fifo_full !== 1'b1) begin bad++; $display("FAIL ovf_full got=%b exp=1", fifo_full); end
        @(negedge clk);
        wren = 1'b0; flag_clr = 1'b1;
        @(posedge clk); #1;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
        @(negedge clk);
        wren = 1'b1; flag_clr = 1'b1;
        @(posedge clk); #1;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set_wins got=%b exp=1", overflow); end
        @(negedge clk);
        wren = 1'b0; flag_clr = 1'b1;
        @(posedge clk); #1;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr2 got=%b exp=0", overflow); end
        @(negedge clk);
        flag_clr = 1'b0;
    endtask

    task automatic test_stream();
        stream_exp = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
        for (int k = 0; k < 10; k++) begin
            if (k != 0) @(negedge clk);
            wren = 1'b1; rden = 1'b1;
            d_in = 8'h21 + 8'(k);
            @(posedge clk); #1;
            total++; if (count !== 3'd5) begin bad++; $display("FAIL stream_count[%0d] got=%0d exp=5", k, count); end
            total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%b exp=1", k, rd_valid); end
`ifdef SYNC_FIFO_FWFT_EN
            total++; if (d_out !== stream_exp[k + 1]) begin bad++; $display("FAIL stream_data[%0d] got=%0h exp=%0h", k, d_out, stream_exp[k + 1]); end
`else
            total++; if (d_out !== stream_exp[k]) begin bad++; $display("FAIL stream_data[%0d] got=%0h exp=%0h", k, d_out, stream_exp[k]); end
`endif
        end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL stream_ovf got=%b exp=1", overflow); end
        @(negedge clk);
        wren = 1'b0; rden = 1'b0; flag_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flag_clr = 1'b0;
        for (int j = 0; j < 5; j++) begin
            if (j != 0) @(negedge clk);
`ifdef SYNC_FIFO_FWFT_EN
            total++; if (d_out !== 8'h26 + 8'(j)) begin bad++; $display("FAIL drain_data[%0d] got=%0h exp=%0h", j, d_out, 8'h26 + 8'(j)); end
`endif
            rden = 1'b1;
            @(posedge clk); #1;
`ifndef SYNC_FIFO_FWFT_EN
            total++; if (d_out !== 8'h26 + 8'(j)) begin bad++; $display("FAIL drain_data[%0d] got=%0h exp=%0h", j, d_out, 8'h26 + 8'(j)); end
            total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL drain_valid[%0d] got=%b exp=1", j, rd_valid); end
`endif
            total++; if (count !== 3'(4 - j)) begin bad++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", j, count, 4 - j); end
        end
        @(negedge clk);
        rden = 1'b0;
        total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b exp=1", fifo_empty); end
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL drain_udf got=%b exp=0", underflow); end
    endtask

    task automatic test_underflow();
        @(negedge clk);
        rden = 1'b1; wren = 1'b1; d_in = 8'hAA;
        @(posedge clk); #1;
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL udf_set got=%b exp=1", underflow); end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL udf_count got=%0d exp=1", count); end
        total++; if (fifo_empty !== 1'b0) begin bad++; $display("FAIL udf_empty got=%b exp=0", fifo_empty); end
        total++; if (almost_empty !== 1'b1) begin bad++; $display("FAIL udf_ae got=%b exp=1", almost_empty); end
`ifdef SYNC_FIFO_FWFT_EN
        total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL udf_valid got=%b exp=1", rd_valid); end
        total++; if (d_out !== 8'hAA) begin bad++; $display("FAIL udf_head got=%0h exp=aa", d_out); end
`else
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL udf_valid got=%b exp=0", rd_valid); end
        total++; if (d_out !== 8'h2A) begin bad++; $display("FAIL udf_hold got=%0h exp=2a", d_out); end
`endif
        @(negedge clk);
        wren = 1'b0; rden = 1'b0; flag_clr = 1'b1;
        @(posedge clk); #1;
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL udf_clr got=%b exp=0", underflow); end
        @(negedge clk);
        flag_clr = 1'b0; rden = 1'b1;
        @(posedge clk); #1;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL udf_pop_count got=%0d exp=0", count); end
`ifndef SYNC_FIFO_FWFT_EN
        total++; if (d_out !== 8'hAA || rd_valid !== 1'b1) begin bad++; $display("FAIL udf_pop got=%0h/%b exp=aa/1", d_out, rd_valid); end
`endif
        @(negedge clk);
        rden = 1'b0;
        @(posedge clk); #1;
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL udf_valid_drop got=%b exp=0", rd_valid); end
    endtask

    task automatic test_read_latency();
        @(negedge clk);
        wren = 1'b1; d_in = 8'h3C;
        @(posedge clk); #1;
        total++; if (count !== 3'd1) begin bad++; $display("FAIL lat_count got=%0d exp=1", count); end
`ifdef SYNC_FIFO_FWFT_EN
        total++; if (d_out !== 8'h3C || rd_valid !== 1'b1) begin bad++; $display("FAIL lat_fwft_pre got=%0h/%b exp=3c/1", d_out, rd_valid); end
`else
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL lat_pre_valid got=%b exp=0", rd_valid); end
`endif
        @(negedge clk);
        wren = 1'b0; rden = 1'b1;
        @(posedge clk); #1;
`ifdef SYNC_FIFO_FWFT_EN
        total++; if (rd_valid !== 1'b0 || fifo_empty !== 1'b1) begin bad++; $display("FAIL lat_fwft_pop got=%b/%b exp=0/1", rd_valid, fifo_empty); end
`else
        total++; if (d_out !== 8'h3C || rd_valid !== 1'b1) begin bad++; $display("FAIL lat_read got=%0h/%b exp=3c/1", d_out, rd_valid); end
`endif
        @(negedge clk);
        rden = 1'b0;
        @(posedge clk); #1;
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL lat_valid_pulse got=%b exp=0", rd_valid); end
`ifndef SYNC_FIFO_FWFT_EN
        total++; if (d_out !== 8'h3C) begin bad++; $display("FAIL lat_hold got=%0h exp=3c", d_out); end
`endif
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wren = 1'b1;
            d_in = 8'h41 + 8'(i);
        end
        @(negedge clk);
        wren = 1'b0;
        total++; if (count !== 3'd4) begin bad++; $display("FAIL mrst_pre_count got=%0d exp=4", count); end
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL mrst_count got=%0d exp=0", count); end
        total++; if (fifo_empty !== 1'b1 || almost_empty !== 1'b1) begin bad++; $display("FAIL mrst_empty got=%b%b exp=11", fifo_empty, almost_empty); end
        total++; if (fifo_full !== 1'b0 || almost_full !== 1'b0) begin bad++; $display("FAIL mrst_full got=%b%b exp=00", fifo_full, almost_full); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL mrst_valid got=%b exp=0", rd_valid); end
`ifndef SYNC_FIFO_FWFT_EN
        total++; if (d_out !== 8'h00) begin bad++; $display("FAIL mrst_d_out got=%0h exp=0", d_out); end
`endif
        #2 rst = 1'b1;
        @(negedge clk);
        wren = 1'b1; d_in = 8'h55;
        @(posedge clk); #1;
        total++; if (count !== 3'd1) begin bad++; $display("FAIL mrst_wr_count got=%0d exp=1", count); end
`ifdef SYNC_FIFO_FWFT_EN
        total++; if (d_out !== 8'h55) begin bad++; $display("FAIL mrst_head got=%0h exp=55", d_out); end
`endif
        @(negedge clk);
        wren = 1'b0; rden = 1'b1;
        @(posedge clk); #1;
`ifndef SYNC_FIFO_FWFT_EN
        total++; if (d_out !== 8'h55 || rd_valid !== 1'b1) begin bad++; $display("FAIL mrst_read got=%0h/%b exp=55/1", d_out, rd_valid); end
`endif
        total++; if (count !== 3'd0) begin bad++; $display("FAIL mrst_rd_count got=%0d exp=0", count); end
        @(negedge clk);
        rden = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_fill();
        test_overflow();
        test_stream();
        test_underflow();
        test_read_latency();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
